// File: rtl/maxpool2x2_stream_pkg.sv
`default_nettype none
// ============================================================================
// Package     : maxpool_pkg
// Description : Shared definitions for the 2x2/stride-2 FP32 max-pool stage.
//               FP32 field positions and the row-phase state type.
// Revision    : 1.0 - initial release
// ============================================================================
package maxpool_pkg;

  // FP32 field positions
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;
  localparam int MAN_LSB  = 0;

  // Row phase: even rows build the line buffer, odd rows produce results
  typedef enum logic [0:0] {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } phase_t;

endpackage : maxpool_pkg
`default_nettype wire

// File: rtl/maxpool2x2_stream_if.sv
`default_nettype none
// ============================================================================
// Interface   : maxpool2x2_stream_if
// Description : Single valid/ready data stream.
//   data  - payload word (DATA_BITS)
//   valid - payload valid, driven by master
//   ready - sink can accept, driven by slave
//   modport master : drives data/valid, observes ready
//   modport slave  : observes data/valid, drives ready
// Revision    : 1.0 - initial release
// ============================================================================
interface maxpool2x2_stream_if #(
  parameter int DATA_BITS = 32
);

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface : maxpool2x2_stream_if
`default_nettype wire

// File: rtl/maxpool2x2_stream_fp32_max2.sv
`default_nettype none
// ============================================================================
// Module      : fp32_max2
// Description : Combinational FP32 two-operand maximum, sign-magnitude order.
//   a, b - operands (first operand wins full ties)
//   y    - larger operand
//   A sign-clear operand beats a sign-set one (+0 beats -0). With equal signs
//   the {exponent, mantissa} field decides: larger wins when positive, smaller
//   wins when negative. NaN/Inf are ordered purely by bit pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_max2
  import maxpool_pkg::*;
(
  input  wire logic [SIGN_BIT:0] a,
  input  wire logic [SIGN_BIT:0] b,
  output logic      [SIGN_BIT:0] y
);

  logic                 sign_a;
  logic                 sign_b;
  logic [EXP_MSB:MAN_LSB] mag_a;
  logic [EXP_MSB:MAN_LSB] mag_b;

  assign sign_a = a[SIGN_BIT];
  assign sign_b = b[SIGN_BIT];
  assign mag_a  = a[EXP_MSB:MAN_LSB];
  assign mag_b  = b[EXP_MSB:MAN_LSB];

  always_comb begin
    y = a;
    if (sign_a != sign_b) begin
      y = sign_a ? b : a;
    end else if (!sign_a) begin
      // both positive: strictly larger magnitude displaces the first operand
      y = (mag_b > mag_a) ? b : a;
    end else begin
      // both negative: strictly smaller magnitude is the larger value
      y = (mag_b < mag_a) ? b : a;
    end
  end

endmodule : fp32_max2
`default_nettype wire

// File: rtl/maxpool2x2_stream.sv
`default_nettype none
// ============================================================================
// Module      : maxpool2x2_stream
// Description : Streaming 2x2/stride-2 FP32 max-pool. Pixels arrive row-major;
//               even rows fold pixel pairs into a half-width line buffer, odd
//               rows fold pairs and combine with the line buffer to emit one
//               pooled value per window.
// Ports       :
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   in_s       - input pixel stream (slave)
//   out_s      - pooled output stream (master), data/valid registered
//   frame_done - one-cycle pulse after the last pixel of a frame is accepted
// Parameters  : DATA_BITS (fixed 32, FP32), IMG_W / IMG_H (even, >= 2)
// Build macro : MAXPOOL_RELU_EN - when defined, negative results become +0
// Revision    : 1.0 - initial release
// ============================================================================
module maxpool2x2_stream
  import maxpool_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  maxpool2x2_stream_if.slave  in_s,
  maxpool2x2_stream_if.master out_s,
  output logic               frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int LB_D  = IMG_W / 2;
  localparam int LB_AW = (IMG_W > 2) ? $clog2(LB_D) : 1;

  logic [COL_W-1:0]     col;
  logic [ROW_W-1:0]     row;
  phase_t               phase;
  logic [DATA_BITS-1:0] pair_reg;
  logic [DATA_BITS-1:0] out_data_reg;
  logic                 out_valid_reg;
  logic [DATA_BITS-1:0] linebuf [0:LB_D-1];

  logic                 accept;
  logic                 col_last;
  logic                 row_last;
  logic                 completing;
  logic                 load_result;
  logic [LB_AW-1:0]     lb_idx;
  logic [DATA_BITS-1:0] pair_max;
  logic [DATA_BITS-1:0] vert_max;
  logic [DATA_BITS-1:0] result;

  assign col_last   = (col == COL_W'(IMG_W - 1));
  assign row_last   = (row == ROW_W'(IMG_H - 1));
  // Only the beat that closes a window can be blocked by a held output
  assign completing = (phase == PH_ODD) && col[0];
  assign in_s.ready = !completing || !out_valid_reg || out_s.ready;
  assign accept     = in_s.valid && in_s.ready;
  assign load_result = accept && completing;

  // Line buffer slot is the pixel-pair index within the row
  if (IMG_W > 2) begin : g_lb_idx_multi
    assign lb_idx = col[COL_W-1:1];
  end else begin : g_lb_idx_single
    assign lb_idx = '0;
  end

  fp32_max2 u_pair_max (
    .a (pair_reg),
    .b (in_s.data),
    .y (pair_max)
  );

  fp32_max2 u_vert_max (
    .a (linebuf[lb_idx]),
    .b (pair_max),
    .y (vert_max)
  );

`ifdef MAXPOOL_RELU_EN
  assign result = vert_max[SIGN_BIT] ? '0 : vert_max;
`else
  assign result = vert_max;
`endif

  // Line buffer carries no reset: every slot is rewritten in the even row
  // before the odd row reads it.
  always_ff @(posedge clk) begin
    if (accept && (phase == PH_EVEN) && col[0]) begin
      linebuf[lb_idx] <= pair_max;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col           <= '0;
      row           <= '0;
      phase         <= PH_EVEN;
      pair_reg      <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= accept && row_last && col_last;

      if (accept) begin
        if (!col[0]) begin
          pair_reg <= in_s.data;
        end
        if (col_last) begin
          col   <= '0;
          phase <= (phase == PH_EVEN) ? PH_ODD : PH_EVEN;
          row   <= row_last ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end

      // A new result replaces a consumed one in the same cycle without a gap
      if (load_result) begin
        out_data_reg  <= result;
        out_valid_reg <= 1'b1;
      end else if (out_valid_reg && out_s.ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_s.data  = out_data_reg;
  assign out_s.valid = out_valid_reg;

endmodule : maxpool2x2_stream
`default_nettype wire

// File: tb/tb_maxpool2x2_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_maxpool2x2_stream
// Description : Self-checking bench for maxpool2x2_stream on a 4x2 image.
//               Expected values come from a frame-level pooling model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maxpool2x2_stream;

  localparam int W = 4;
  localparam int H = 2;
  localparam int N = W * H;

  logic clk;
  logic rst_n;
  logic frame_done;

  maxpool2x2_stream_if #(.DATA_BITS(32)) in_s ();
  maxpool2x2_stream_if #(.DATA_BITS(32)) out_s ();

  maxpool2x2_stream #(
    .DATA_BITS (32),
    .IMG_W     (W),
    .IMG_H     (H)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_s       (in_s),
    .out_s      (out_s),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int fd_cnt   = 0;
  logic [31:0] got_q [$];
  logic [31:0] exp_q [$];

  // Output beat and frame_done monitor
  always @(negedge clk) begin
    if (out_s.valid && out_s.ready) got_q.push_back(out_s.data);
    if (frame_done) fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Ordering key: positives above negatives, larger value gives larger key
  function automatic logic [31:0] fp_key(input logic [31:0] x);
    return x[31] ? {1'b0, ~x[30:0]} : {1'b1, x[30:0]};
  endfunction

  // Pool one whole row-major frame and append results to exp_q
  task automatic model_frame(input logic [31:0] px [$]);
    for (int wr = 0; wr < H / 2; wr++) begin
      for (int wc = 0; wc < W / 2; wc++) begin
        logic [31:0] best;
        best = px[(2 * wr) * W + 2 * wc];
        for (int dr = 0; dr < 2; dr++) begin
          for (int dc = 0; dc < 2; dc++) begin
            logic [31:0] v;
            v = px[(2 * wr + dr) * W + 2 * wc + dc];
            if (fp_key(v) > fp_key(best)) best = v;
          end
        end
`ifdef MAXPOOL_RELU_EN
        if (best[31]) best = 32'h0;
`endif
        exp_q.push_back(best);
      end
    end
  endtask

  function automatic logic [31:0] rand_px();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Present one pixel; returns with it accepted and valid still asserted
  task automatic push_pixel(input logic [31:0] d, output int waits);
    in_s.data  = d;
    in_s.valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!in_s.ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (waits == 50) check("push_timeout", {31'b0, in_s.ready}, 32'h1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_seq(input logic [31:0] q [$], output int stalls);
    int w;
    stalls = 0;
    foreach (q[i]) begin
      push_pixel(q[i], w);
      stalls += w;
    end
    in_s.valid = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic start_test();
    got_q.delete();
    exp_q.delete();
    fd_cnt = 0;
  endtask

  initial begin
    logic [31:0] px [$];
    logic [31:0] all_px [$];
    int stalls;
    int w;

    rst_n       = 1'b0;
    in_s.data   = '0;
    in_s.valid  = 1'b0;
    out_s.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_in_ready",   {31'b0, in_s.ready},  32'h1);
    check("rst_out_valid",  {31'b0, out_s.valid}, 32'h0);
    check("rst_out_data",   out_s.data,           32'h0);
    check("rst_frame_done", {31'b0, frame_done},  32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reference frame from the plan
    start_test();
    px = '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'hC0000000,
           32'h3F000000, 32'h3F800000, 32'h00000000, 32'hBF000000};
    model_frame(px);
    send_seq(px, stalls);
    drain();
    check_outputs("basic");
    check("basic_frame_done", fd_cnt, 1);

    // All-negative window and signed-zero window
    start_test();
    px = '{32'hBF800000, 32'hC0000000, 32'h80000000, 32'h00000000,
           32'hBF000000, 32'hC0400000, 32'h80000000, 32'h80000000};
    model_frame(px);
    send_seq(px, stalls);
    drain();
    check_outputs("neg_zero");

    // All -0 window, and NaN/Inf ordered by bit pattern
    start_test();
    px = '{32'h80000000, 32'h80000000, 32'h7F800000, 32'h7FC00000,
           32'h80000000, 32'h80000000, 32'hFF800000, 32'h00000001};
    model_frame(px);
    send_seq(px, stalls);
    drain();
    check_outputs("negzero_nan");

    // Backpressure across two windows
    start_test();
    px.delete();
    for (int i = 0; i < N; i++) px.push_back(rand_px());
    model_frame(px);
    out_s.ready = 1'b0;
    stalls = 0;
    for (int i = 0; i < N - 1; i++) begin
      push_pixel(px[i], w);
      stalls += w;
    end
    check("hold_no_early_stall", stalls, 0);
    in_s.data  = px[N - 1];
    in_s.valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_in_ready",  {31'b0, in_s.ready},  32'h0);
      check("hold_out_valid", {31'b0, out_s.valid}, 32'h1);
      check("hold_out_data",  out_s.data,           exp_q[0]);
    end
    @(posedge clk);
    #1;
    out_s.ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", {31'b0, in_s.ready}, 32'h1);
    @(posedge clk);
    #1;
    in_s.valid = 1'b0;
    drain();
    check_outputs("hold");

    // Reset mid-frame after 5 of 8 pixels
    start_test();
    px.delete();
    for (int i = 0; i < 5; i++) px.push_back(rand_px());
    send_seq(px, stalls);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_out_valid", {31'b0, out_s.valid}, 32'h0);
    check("midrst_in_ready",  {31'b0, in_s.ready},  32'h1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    px.delete();
    for (int i = 0; i < N; i++) px.push_back(rand_px());
    model_frame(px);
    send_seq(px, stalls);
    drain();
    check_outputs("midrst");
    check("midrst_frame_done", fd_cnt, 1);

    // Back-to-back random frames with continuous valid/ready
    start_test();
    all_px.delete();
    for (int f = 0; f < 4; f++) begin
      px.delete();
      for (int i = 0; i < N; i++) px.push_back(rand_px());
      model_frame(px);
      foreach (px[i]) all_px.push_back(px[i]);
    end
    send_seq(all_px, stalls);
    drain();
    check("b2b_stalls", stalls, 0);
    check("b2b_frame_done", fd_cnt, 4);
    check_outputs("b2b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_maxpool2x2_stream
`default_nettype wire
